mul8_rr_arbiter: RTL and testbench

// - Shares one signed 8x8 radix-4 Booth/Wallace multiplier core among NREQ requesters.
// - Core is instantiated inside this block; its 16-bit product is registered into a one-entry result buffer.
// - Arbitration is round-robin, so each requester sees a fair share of the core.
// - Sits between the integer execute units and the single shared multiplier.

---
 rtl/mul8_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mul8_rr_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_rr_arbiter.sv
// Round-robin front end that time-shares one signed 8x8 radix-4 Booth/Wallace multiplier
// among NREQ requesters, with a one-entry registered result buffer per accepted op.

module mul8_booth_core (
   input  logic [7:0]  i_a,
   input  logic [7:0]  i_b,
   output logic [15:0] o_sumout
);
   logic [8:0]  w_bx;
   logic [15:0] w_pp [4];
   logic [15:0] w_s1, w_c1, w_s2, w_c2;

   // Signed partial product for one radix-4 Booth digit, before positional shift.
   function automatic logic [15:0] booth_row(input logic [2:0] sel, input logic [7:0] a);
      logic [15:0] v_a;
      logic [15:0] v_row;
      v_a = {{8{a[7]}}, a};
      case (sel)
         3'b001, 3'b010: v_row = v_a;
         3'b011:         v_row = v_a << 1;
         3'b100:         v_row = (~(v_a << 1)) + 16'd1;
         3'b101, 3'b110: v_row = (~v_a) + 16'd1;
         default:        v_row = 16'd0;
      endcase
      return v_row;
   endfunction

   // 3:2 carry-save compressor; result is {carry, sum}, carry already weighted by 2.
   function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
      logic [15:0] v_sum;
      logic [15:0] v_cry;
      v_sum = x ^ y ^ z;
      v_cry = ((x & y) | (x & z) | (y & z)) << 1;
      return {v_cry, v_sum};
   endfunction

   assign w_bx = {i_b, 1'b0};

   for (genvar g = 0; g < 4; g++) begin : g_pp
      assign w_pp[g] = booth_row(w_bx[2*g+2:2*g], i_a) << (2*g);
   end

   // Two compressor levels reduce four rows to two; everything is modulo 2^16, and the
   // 16-bit signed result is exact, so the final adder's carry-out is simply dropped.
   assign {w_c1, w_s1} = csa(w_pp[0], w_pp[1], w_pp[2]);
   assign {w_c2, w_s2} = csa(w_s1, w_c1, w_pp[3]);
   assign o_sumout     = w_s2 + w_c2;
endmodule

module mul8_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [15:0]       resp_product
);
   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDW-1:0]    r_rr_ptr;
   logic [IDW-1:0]    r_owner;
   logic [NREQ-1:0]   r_resp_valid;
   logic [15:0]       r_product;

   logic [IDW-1:0]    w_winner;
   logic              w_found;
   logic              w_drain;
   logic              w_can_take;
   logic              w_accept;
   logic [NREQ-1:0]   w_grant;
   logic [7:0]        w_op_a;
   logic [7:0]        w_op_b;
   logic [15:0]       w_sumout;

   // Round-robin search starting just after the last accepted requester.
   always_comb begin
      int v_idx;
      w_winner = '0;
      w_found  = 1'b0;
      v_idx    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         v_idx = int'(r_rr_ptr) + k;
         if (v_idx >= NREQ) begin
            v_idx = v_idx - NREQ;
         end else begin
            v_idx = v_idx;
         end
         if (!w_found && req_valid[v_idx]) begin
            w_found  = 1'b1;
            w_winner = v_idx[IDW-1:0];
         end else begin
            w_found  = w_found;
         end
      end
   end

   assign w_drain    = (r_state == ST_FULL) && resp_ready[r_owner];
   assign w_can_take = (r_state == ST_EMPTY) || w_drain;
   assign w_accept   = w_can_take && w_found;
   assign w_grant    = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_winner) : {NREQ{1'b0}};
   assign w_op_a     = req_a[8*w_winner +: 8];
   assign w_op_b     = req_b[8*w_winner +: 8];

   mul8_booth_core u_core (
      .i_a      (w_op_a),
      .i_b      (w_op_b),
      .o_sumout (w_sumout)
   );

   // Result buffer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Buffer next state: a drain with a simultaneous accept keeps it full with no bubble.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_FULL;
            end else begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_drain && !w_accept) begin
               w_state_nxt = ST_EMPTY;
            end else begin
               w_state_nxt = ST_FULL;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Capture product, owner and pointer on accept; clear the valid flag on a plain drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_valid <= '0;
         r_product    <= 16'h0000;
         r_owner      <= '0;
         r_rr_ptr     <= IDW'(NREQ - 1);
      end else if (w_accept) begin
         r_resp_valid <= w_grant;
         r_product    <= w_sumout;
         r_owner      <= w_winner;
         r_rr_ptr     <= w_winner;
      end else if (w_drain) begin
         r_resp_valid <= '0;
      end
   end

   assign req_ready    = w_grant;
   assign resp_valid   = r_resp_valid;
   assign resp_product = r_product;
endmodule

// File: tb/tb_mul8_rr_arbiter.sv
// Self-checking bench for mul8_rr_arbiter: directed scenarios plus an exhaustive
// randomized sweep scored against a transaction-level model of the arbiter and buffer.

module tb_mul8_rr_arbiter;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*8-1:0] req_a = '0;
   logic [NREQ*8-1:0] req_b = '0;
   logic [NREQ-1:0]   resp_valid;
   logic [NREQ-1:0]   resp_ready = '0;
   logic [15:0]       resp_product;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: buffer occupancy, its owner and product, and the last granted requester.
   bit              m_full    = 1'b0;
   int              m_owner   = 0;
   logic [15:0]     m_prod    = 16'h0000;
   int              m_last    = NREQ - 1;
   int              exp_win   = -1;
   logic [NREQ-1:0] exp_ready = '0;
   logic [NREQ-1:0] exp_resp  = '0;
   int              n_drained = 0;

   mul8_rr_arbiter #(.NREQ(NREQ)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_product (resp_product)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_full  = 1'b0;
      m_owner = 0;
      m_last  = NREQ - 1;
   endtask

   // Expected grant and response for the inputs currently applied.
   task automatic model_eval();
      int  i;
      bit  can_take;
      can_take = !m_full || resp_ready[m_owner];
      exp_win  = -1;
      for (int k = 1; k <= NREQ; k++) begin
         i = (m_last + k) % NREQ;
         if (exp_win < 0 && req_valid[i]) exp_win = i;
      end
      if (!can_take) exp_win = -1;
      exp_ready = '0;
      if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
      exp_resp = '0;
      if (m_full) exp_resp[m_owner] = 1'b1;
   endtask

   task automatic model_commit();
      bit               drain;
      logic signed [7:0] sa;
      logic signed [7:0] sb;
      int               p;
      drain = m_full && resp_ready[m_owner];
      if (drain) n_drained++;
      if (exp_win >= 0) begin
         sa      = req_a[8*exp_win +: 8];
         sb      = req_b[8*exp_win +: 8];
         p       = int'(sa) * int'(sb);
         m_prod  = p[15:0];
         m_full  = 1'b1;
         m_owner = exp_win;
         m_last  = exp_win;
      end else if (drain) begin
         m_full = 1'b0;
      end
   endtask

   // Apply inputs just after a falling edge and evaluate the model.
   task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*8-1:0] a,
                        input logic [NREQ*8-1:0] b, input logic [NREQ-1:0] rr);
      req_valid  = v;
      req_a      = a;
      req_b      = b;
      resp_ready = rr;
      #1;
      model_eval();
   endtask

   task automatic advance();
      model_commit();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid  = '0;
      resp_ready = '0;
      rst        = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      n_tests++;
      if (resp_valid !== 4'b0000) begin
         n_fail++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid);
      end
      n_tests++;
      if (resp_product !== 16'h0000) begin
         n_fail++; $display("FAIL reset_product: got %h expected 0000", resp_product);
      end
      n_tests++;
      if (req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      drive(4'b0001, 32'h0000_0005, 32'h0000_0003, 4'b0000);
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready);
      end
      advance();
      drive(4'b0000, '0, '0, 4'b0001);
      n_tests++;
      if (resp_valid !== 4'b0001 || resp_product !== 16'h000F) begin
         n_fail++; $display("FAIL single_result: got %b/%h expected 0001/000f", resp_valid, resp_product);
      end
      advance();
      drive(4'b0000, '0, '0, 4'b0000);
      n_tests++;
      if (resp_valid !== 4'b0000) begin
         n_fail++; $display("FAIL single_drain: got %b expected 0000", resp_valid);
      end
   endtask

   task automatic test_corners();
      logic [7:0]        ca [4] = '{8'h80, 8'h80, 8'hFF, 8'h00};
      logic [7:0]        cb [4] = '{8'h80, 8'h7F, 8'h01, 8'h9C};
      logic [15:0]       cp [4] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000};
      logic [NREQ*8-1:0] av;
      logic [NREQ*8-1:0] bv;
      logic [NREQ-1:0]   oh;
      int                j;
      for (int c = 0; c < 4; c++) begin
         j  = $urandom_range(NREQ - 1, 0);
         av = '0;
         bv = '0;
         oh = '0;
         av[8*j +: 8] = ca[c];
         bv[8*j +: 8] = cb[c];
         oh[j]        = 1'b1;
         drive(oh, av, bv, 4'b1111);
         n_tests++;
         if (req_ready !== oh) begin
            n_fail++; $display("FAIL corner_grant[%0d]: got %b expected %b", c, req_ready, oh);
         end
         advance();
         drive(4'b0000, '0, '0, 4'b0000);
         n_tests++;
         if (resp_valid !== oh || resp_product !== cp[c]) begin
            n_fail++; $display("FAIL corner_product[%0d]: got %b/%h expected %b/%h",
                               c, resp_valid, resp_product, oh, cp[c]);
         end
         advance();
      end
      drive(4'b0000, '0, '0, 4'b1111);
      advance();
   endtask

   task automatic test_fairness();
      int              seq [6] = '{0, 1, 2, 3, 0, 1};
      logic [NREQ-1:0] e;
      logic [NREQ-1:0] prev;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(4'b1111, NREQ*8'($urandom), NREQ*8'($urandom), 4'b1111);
         e = '0;
         e[seq[c]] = 1'b1;
         n_tests++;
         if (req_ready !== e) begin
            n_fail++; $display("FAIL fair_grant[%0d]: got %b expected %b", c, req_ready, e);
         end
         if (c > 0) begin
            prev = '0;
            prev[seq[c-1]] = 1'b1;
            n_tests++;
            if (resp_valid !== prev || resp_product !== m_prod) begin
               n_fail++; $display("FAIL fair_resp[%0d]: got %b/%h expected %b/%h",
                                  c, resp_valid, resp_product, prev, m_prod);
            end
         end
         advance();
      end
      drive(4'b0000, '0, '0, 4'b1111);
      n_tests++;
      if (resp_valid !== 4'b0010 || resp_product !== m_prod) begin
         n_fail++; $display("FAIL fair_last: got %b/%h expected 0010/%h", resp_valid, resp_product, m_prod);
      end
      advance();
   endtask

   task automatic test_backpressure();
      logic [NREQ-1:0] rr;
      drive(4'b1111, NREQ*8'($urandom), NREQ*8'($urandom), 4'b1111);
      advance();
      for (int c = 0; c < 3; c++) begin
         rr = 4'b1111;
         rr[m_owner] = 1'b0;
         drive(4'b1111, NREQ*8'($urandom), NREQ*8'($urandom), rr);
         n_tests++;
         if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready);
         end
         n_tests++;
         if (resp_valid !== exp_resp || resp_product !== m_prod) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h expected %b/%h",
                               c, resp_valid, resp_product, exp_resp, m_prod);
         end
         advance();
      end
      drive(4'b1111, NREQ*8'($urandom), NREQ*8'($urandom), 4'b1111);
      n_tests++;
      if (req_ready !== exp_ready || exp_ready == 4'b0000) begin
         n_fail++; $display("FAIL bp_release_grant: got %b expected %b", req_ready, exp_ready);
      end
      advance();
      drive(4'b0000, '0, '0, 4'b1111);
      n_tests++;
      if (resp_valid !== exp_resp || resp_product !== m_prod) begin
         n_fail++; $display("FAIL bp_reload: got %b/%h expected %b/%h", resp_valid, resp_product, exp_resp, m_prod);
      end
      advance();
   endtask

   task automatic test_reset_midop();
      drive(4'b0100, 32'h0011_2233, 32'h0044_5566, 4'b0000);
      advance();
      drive(4'b0000, '0, '0, 4'b0000);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (resp_valid !== 4'b0000 || resp_product !== 16'h0000) begin
         n_fail++; $display("FAIL midop_async_clear: got %b/%h expected 0000/0000", resp_valid, resp_product);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(4'b0011, 32'h0000_0302, 32'h0000_0405, 4'b1111);
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL midop_priority: got %b expected 0001", req_ready);
      end
      advance();
      drive(4'b0000, '0, '0, 4'b1111);
      n_tests++;
      if (resp_valid !== 4'b0001 || resp_product !== 16'h000A) begin
         n_fail++; $display("FAIL midop_result: got %b/%h expected 0001/000a", resp_valid, resp_product);
      end
      advance();
   endtask

   task automatic test_random();
      bit                pend [NREQ];
      logic [7:0]        pa   [NREQ];
      logic [7:0]        pb   [NREQ];
      logic [NREQ-1:0]   v;
      logic [NREQ-1:0]   rr;
      logic [NREQ*8-1:0] av;
      logic [NREQ*8-1:0] bv;
      int                next_pair = 0;
      int                n_pend    = 0;
      int                cyc       = 0;
      do_reset();
      n_drained = 0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      while ((next_pair < 65536 || n_pend > 0 || m_full) && cyc < 90000) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && next_pair < 65536) begin
               pend[i] = 1'b1;
               pa[i]   = next_pair[15:8];
               pb[i]   = next_pair[7:0];
               next_pair++;
               n_pend++;
            end
            v[i]         = pend[i] && ($urandom_range(15, 0) != 0);
            av[8*i +: 8] = pa[i];
            bv[8*i +: 8] = pb[i];
         end
         rr = NREQ'($urandom);
         if (m_full) rr[m_owner] = ($urandom_range(31, 0) != 0);
         drive(v, av, bv, rr);
         n_tests++;
         if (req_ready !== exp_ready) begin
            n_fail++; $display("FAIL rand_grant@%0d: got %b expected %b", cyc, req_ready, exp_ready);
         end
         n_tests++;
         if (resp_valid !== exp_resp) begin
            n_fail++; $display("FAIL rand_owner@%0d: got %b expected %b", cyc, resp_valid, exp_resp);
         end
         if (m_full) begin
            n_tests++;
            if (resp_product !== m_prod) begin
               n_fail++; $display("FAIL rand_product@%0d: got %h expected %h", cyc, resp_product, m_prod);
            end
         end
         if (exp_win >= 0) begin
            pend[exp_win] = 1'b0;
            n_pend--;
         end
         advance();
         cyc++;
      end
      n_tests++;
      if (cyc >= 90000) begin
         n_fail++; $display("FAIL rand_timeout: got %0d cycles expected < 90000", cyc);
      end
      n_tests++;
      if (n_drained != 65536) begin
         n_fail++; $display("FAIL rand_delivered: got %0d expected 65536", n_drained);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_corners();
      test_fairness();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
